// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch sequencer for a 1-cycle registered IRAM.
// Walks IDLE -> ISSUE -> WAIT -> VALID, holding the captured word until the
// consumer takes it, then advances PC sequentially or to a jump target.
// Optional halt detection is enabled by defining IFETCH_HALT_DETECT_EN; without
// it the HALTED state is unreachable and halt-opcode words fetch normally.
module ifetch_ctrl #(
  parameter logic [7:0] START_ADDR  = 8'd0,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  iram_addr,
  input  logic [15:0] iram_q,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  output logic        busy,
  output logic        halted
);

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 4;

`ifdef IFETCH_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_VALID  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] instr_q;
  logic [AW-1:0] instr_pc_q;
  logic          valid_q;
  logic          busy_q;
  logic          halted_q;

  // Combinational helpers for the VALID-state decision
  logic          xfer_c;
  logic          is_halt_c;
  logic [AW-1:0] pc_seq_c;
  logic [AW-1:0] pc_d;

  // A transfer is only possible while a word is being presented
  assign xfer_c    = valid_q & instr_ready;
  assign is_halt_c = HaltEn & (instr_q[DW-1 -: OPW] == HALT_OPCODE);
  assign pc_seq_c  = pc_q + AW'(1);
  assign pc_d      = jump_en ? jump_addr : pc_seq_c;

  // Fetch FSM with all outputs held in registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= START_ADDR;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          // iram_addr already equals PC; RAM samples it at this edge
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          instr_q    <= iram_q;
          instr_pc_q <= pc_q;
          valid_q    <= 1'b1;
          state_q    <= S_VALID;
        end
        S_VALID: begin
          if (xfer_c) begin
            valid_q <= 1'b0;
            if (is_halt_c) begin
              // PC stays at the halt word; jump request is dropped
              state_q  <= S_HALTED;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              state_q <= S_ISSUE;
            end
          end
        end
        S_HALTED: begin
          if (start) begin
            pc_q     <= START_ADDR;
            state_q  <= S_ISSUE;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address tracks PC in every state, so it moves on the same edge
  assign iram_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign halted      = HaltEn & halted_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a behavioural 1-cycle registered IRAM.
module tb_ifetch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  iram_addr;
  logic [15:0] iram_q = 16'h0000;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic        busy;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  ifetch_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .iram_addr   (iram_addr),
    .iram_q      (iram_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  // Registered-read instruction RAM
  always @(posedge clock) iram_q <= mem[iram_addr];

  function automatic logic [15:0] exp_word(input logic [7:0] a);
    if (a == 8'h00) return 16'hC0FF;
    if (a == 8'd92) return 16'hF000;
    return 16'h1000 | {8'h00, a};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for instr_valid, then check the presented word
  task automatic fetch_expect(input logic [7:0] exp_pc, input int exp_lat);
    int n;
    n = 0;
    @(negedge clock);
    n = 1;
    while (instr_valid !== 1'b1 && n < 12) begin
      @(negedge clock);
      n++;
    end
    chk("valid_seen", 16'(instr_valid), 16'(1'b1));
    chk("instr_pc", 16'(instr_pc), 16'(exp_pc));
    chk("instr", instr, exp_word(exp_pc));
    chk("addr_in_valid", 16'(iram_addr), 16'(exp_pc));
    chk("busy_in_valid", 16'(busy), 16'(1'b1));
    if (exp_lat > 0) chk("latency", 16'(n), 16'(exp_lat));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, 16'(iram_addr), 16'h0000);
    chk({tag, "_instr"}, instr, 16'h0000);
    chk({tag, "_pc"}, 16'(instr_pc), 16'h0000);
    chk({tag, "_valid"}, 16'(instr_valid), 16'h0000);
    chk({tag, "_busy"}, 16'(busy), 16'h0000);
    chk({tag, "_halted"}, 16'(halted), 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = exp_word(8'(i));

    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk_reset_outs("rst");
    reset = 1'b0;

    // Idle: jump and ready ignored, nothing starts
    instr_ready = 1'b1;
    jump_en     = 1'b1;
    jump_addr   = 8'h33;
    @(negedge clock);
    @(negedge clock);
    chk("idle_addr", 16'(iram_addr), 16'h0000);
    chk("idle_busy", 16'(busy), 16'h0000);
    chk("idle_valid", 16'(instr_valid), 16'h0000);
    jump_en = 1'b0;

    // Start pulse: valid at cycle 3, address 1 at cycle 4
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("issue_busy", 16'(busy), 16'h0001);
    chk("issue_valid", 16'(instr_valid), 16'h0000);
    fetch_expect(8'h00, 2);
    @(negedge clock);
    chk("c4_addr", 16'(iram_addr), 16'h0001);
    chk("c4_valid", 16'(instr_valid), 16'h0000);
    fetch_expect(8'h01, 2);
    for (int p = 2; p <= 5; p++) fetch_expect(8'(p), 3);

    // Stall at pc 5 for 10 cycles, with jump requests that must be ignored
    instr_ready = 1'b0;
    jump_en     = 1'b1;
    jump_addr   = 8'h77;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("stall_instr", instr, exp_word(8'h05));
      chk("stall_pc", 16'(instr_pc), 16'h0005);
      chk("stall_addr", 16'(iram_addr), 16'h0005);
      chk("stall_valid", 16'(instr_valid), 16'h0001);
    end
    jump_en     = 1'b0;
    instr_ready = 1'b1;
    fetch_expect(8'h06, 3);

    // Jump to 0x20, then from 0x20 back to 0x06
    jump_en   = 1'b1;
    jump_addr = 8'h20;
    fetch_expect(8'h20, 3);
    jump_addr = 8'h06;
    fetch_expect(8'h06, 3);
    jump_en = 1'b0;

    // Jump pulse while not valid has no effect
    @(negedge clock);
    jump_en   = 1'b1;
    jump_addr = 8'hAA;
    @(negedge clock);
    jump_en = 1'b0;
    fetch_expect(8'h07, 1);

    // Wrap from FE through FF to 00
    jump_en   = 1'b1;
    jump_addr = 8'hFE;
    fetch_expect(8'hFE, 3);
    jump_en = 1'b0;
    fetch_expect(8'hFF, 3);
    fetch_expect(8'h00, 3);

    // Run into the halt-opcode word at 92
    jump_en   = 1'b1;
    jump_addr = 8'd90;
    fetch_expect(8'd90, 3);
    jump_en = 1'b0;
    fetch_expect(8'd91, 3);
    fetch_expect(8'd92, 3);
`ifdef IFETCH_HALT_DETECT_EN
    @(negedge clock);
    @(negedge clock);
    chk("halt_halted", 16'(halted), 16'h0001);
    chk("halt_busy", 16'(busy), 16'h0000);
    chk("halt_valid", 16'(instr_valid), 16'h0000);
    chk("halt_addr", 16'(iram_addr), 16'(8'd92));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("restart_halted", 16'(halted), 16'h0000);
    fetch_expect(8'h00, 2);
`else
    fetch_expect(8'd93, 3);
    chk("nohalt_halted", 16'(halted), 16'h0000);
`endif

    // Reset asserted in WAIT
    @(negedge clock);
    @(negedge clock);
    chk("wait_busy", 16'(busy), 16'h0001);
    chk("wait_valid", 16'(instr_valid), 16'h0000);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_reset_outs("midrst");
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("postrst_valid", 16'(instr_valid), 16'h0000);
      chk("postrst_busy", 16'(busy), 16'h0000);
    end

    // Reset wins over start in the same cycle
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("prio_busy", 16'(busy), 16'h0000);
    @(negedge clock);
    chk("prio_busy2", 16'(busy), 16'h0000);

    // Fresh start after reset fetches from START_ADDR
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    fetch_expect(8'h00, 2);
    fetch_expect(8'h01, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter START_ADDR, default 8'd0: PC loaded on reset and on restart.
REQ-002 Parameter HALT_OPCODE, default 4'hF: instr[15:12] value treated as halt.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin or resume fetching; sampled in IDLE and HALTED only.
REQ-006 iram_addr  output  8  registered address to instruction RAM (1-cycle registered read).
REQ-007 iram_q  input  16  instruction RAM read data, valid the cycle after iram_addr is presented.
REQ-008 instr  output  16  captured instruction word, held stable while instr_valid=1.
REQ-009 instr_pc  output  8  address of the word in instr.
REQ-010 instr_valid  output  1  instr is valid and awaiting consumption.
REQ-011 instr_ready  input  1  consumer accepts instr; a transfer occurs when instr_valid and instr_ready are both 1 at an edge.
REQ-012 jump_en  input  1  with a transfer, the next PC is jump_addr instead of PC+1.
REQ-013 jump_addr  input  8  jump target.
REQ-014 busy  output  1  high in ISSUE, WAIT and VALID.
REQ-015 halted  output  1  high in HALTED.

Function
REQ-016 The block SHALL implement five states: IDLE, ISSUE, WAIT, VALID, HALTED.
REQ-017 IDLE: iram_addr holds PC; start=1 -> ISSUE; otherwise remain.
REQ-018 ISSUE: iram_addr=PC, stable for the whole cycle; unconditionally -> WAIT.
REQ-019 WAIT: at the edge, instr<=iram_q, instr_pc<=PC; -> VALID.
REQ-020 VALID: instr_valid=1; instr and instr_pc SHALL NOT change until a transfer.
REQ-021 On a transfer with jump_en=0, PC<=PC+1 modulo 256 (8'hFF wraps to 8'h00); -> ISSUE.
REQ-022 On a transfer with jump_en=1, PC<=jump_addr; -> ISSUE.
REQ-023 jump_en and jump_addr SHALL be ignored in all cycles without a transfer.
REQ-024 VALID with instr_ready=0: remain in VALID indefinitely, all outputs held.
REQ-025 Latency: instr_valid SHALL rise exactly 3 cycles after the edge that samples start=1 in IDLE (ISSUE, WAIT, then VALID); steady-state throughput SHALL be one transfer per 3 cycles with instr_ready held high.
REQ-026 iram_addr SHALL equal PC in every state and update on the same edge as PC.
REQ-027 start SHALL be ignored in ISSUE, WAIT and VALID.

Reset
REQ-028 When reset=1 at an edge, in any state including mid-fetch: state<=IDLE, PC<=START_ADDR, iram_addr<=START_ADDR, instr<=16'h0000, instr_pc<=8'h00, instr_valid<=0, busy<=0, halted<=0.
REQ-029 Reset SHALL take priority over start, instr_ready and jump_en in the same cycle.
REQ-030 Any in-flight IRAM read during reset SHALL be discarded; no transfer SHALL be presented for it.

Configuration
REQ-031 Macro IFETCH_HALT_DETECT_EN: when defined, a transfer whose instr[15:12]==HALT_OPCODE SHALL move to HALTED instead of ISSUE, ignoring jump_en; PC is left at the halt word's address.
REQ-032 With IFETCH_HALT_DETECT_EN defined, HALTED: halted=1, instr_valid=0; start=1 -> PC<=START_ADDR, -> ISSUE.
REQ-033 Without IFETCH_HALT_DETECT_EN, HALTED SHALL be unreachable, halted SHALL be tied 0, and HALT_OPCODE words SHALL be treated as ordinary instructions (REQ-021/022).

Verification
REQ-034 Reset, then start pulse at cycle 0, IRAM[0]=16'hC0FF, instr_ready=1 -> instr_valid=1 at cycle 3 with instr=16'hC0FF, instr_pc=0; iram_addr=1 at cycle 4.
REQ-035 instr_ready=0 for 10 cycles in VALID with instr_pc=5 -> instr and instr_pc unchanged, iram_addr=5 throughout; ready=1 -> next instr_pc=6.
REQ-036 Transfer at instr_pc=8'h20 with jump_en=1, jump_addr=8'h06 -> next instr_pc=8'h06; jump_en=1 pulsed while instr_valid=0 -> no effect on PC.
REQ-037 Sequential fetch from 8'hFE with ready=1, no jumps -> instr_pc sequence FE, FF, 00.
REQ-038 With IFETCH_HALT_DETECT_EN, IRAM[92]=16'hF000 reached sequentially -> after its transfer halted=1, busy=0, instr_valid=0; start -> instr_pc=0 three cycles later. Without the macro -> instr_pc=93 follows.
REQ-039 Reset asserted in WAIT -> next cycle all outputs at REQ-028 values, state IDLE, no instr_valid before a new start.
